// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 single-precision fields, exception codes and types (ROUND state only with FPMUL_RNE_EN)
package fp_pkg;
    localparam int MANT_W = 23;
    localparam int EXP_W = 8;
    localparam int BIAS = 127;
    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_UNDER = 2'b01;
    localparam logic [1:0] EXC_OVER = 2'b10;
    localparam logic [1:0] EXC_NAN = 2'b11;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} op_class_t;
    typedef enum logic [2:0] {
        IDLE,
        MUL,
        NORM,
`ifdef FPMUL_RNE_EN
        ROUND,
`endif
        FIN
    } state_t;
endpackage

// File: rtl/fp_operand_classify.sv
// fp_operand_classify: split one single-precision operand into sign/exponent/fraction and class
module fp_operand_classify
    import fp_pkg::*;
(
    input  logic [MANT_W+EXP_W:0] op,
    output logic                  sign,
    output logic [EXP_W-1:0]      exp,
    output logic [MANT_W-1:0]     frac,
    output op_class_t             cls
);
    always_comb begin
        sign = op[MANT_W+EXP_W];
        exp = op[MANT_W+EXP_W-1:MANT_W];
        frac = op[MANT_W-1:0];
        cls = (exp == '0) ? ZERO : (exp != '1) ? NORMAL : (frac == '0) ? INF : NAN;
    end
endmodule

// File: rtl/fp_multiplier_seq.sv
// fp_multiplier_seq: sequential shift-add IEEE-754 multiplier, truncating; FPMUL_RNE_EN adds round-to-nearest-even
module fp_multiplier_seq #(
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int BIAS   = fp_pkg::BIAS
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [MANT_W+EXP_W:0] InputA,
    input  logic [MANT_W+EXP_W:0] InputB,
    output logic [MANT_W+EXP_W:0] AxB,
    output logic                  DONE,
    output logic                  BUSY,
    output logic [1:0]            Exception
);
    import fp_pkg::*;
    localparam int MW = MANT_W + 1;
    localparam int PW = 2 * MW;
    localparam int XW = EXP_W + 2;
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam int CW = $clog2(MW);
    logic                   sa, sb;
    logic [EXP_W-1:0]       ea, eb;
    logic [MANT_W-1:0]      fa, fb;
    op_class_t              ca, cb;
    state_t                 state_q, state_d;
    logic [MW-1:0]          mcand_q, mcand_d, mplier_q, mplier_d;
    logic [PW-1:0]          acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [XW-1:0]   exp_q, exp_d;
    logic [MANT_W-1:0]      frac_q, frac_d;
    logic                   sign_q, sign_d, spec_q, spec_d;
    logic [MANT_W+EXP_W:0]  spec_res_q, spec_res_d, axb_q, axb_d;
    logic [1:0]             spec_exc_q, spec_exc_d, exc_q, exc_d;
    logic                   done_q, done_d, busy_q, busy_d;
    logic                   is_nan, is_inf, is_special, hi;
`ifdef FPMUL_RNE_EN
    logic                   guard_q, guard_d, sticky_q, sticky_d;
    logic [MANT_W:0]        rnd;
`endif
    fp_operand_classify u_cls_a (.op(InputA), .sign(sa), .exp(ea), .frac(fa), .cls(ca));
    fp_operand_classify u_cls_b (.op(InputB), .sign(sb), .exp(eb), .frac(fb), .cls(cb));
    always_comb begin
        is_nan = ca == NAN || cb == NAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF);
        is_inf = ca == INF || cb == INF;
        is_special = ca != NORMAL || cb != NORMAL;
        hi = acc_q[PW-1];
        state_d = state_q;
        mcand_d = mcand_q;
        mplier_d = mplier_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        exp_d = exp_q;
        frac_d = frac_q;
        sign_d = sign_q;
        spec_d = spec_q;
        spec_res_d = spec_res_q;
        spec_exc_d = spec_exc_q;
        axb_d = axb_q;
        exc_d = exc_q;
        done_d = 1'b0;
        busy_d = state_q != IDLE || START;
`ifdef FPMUL_RNE_EN
        guard_d = guard_q;
        sticky_d = sticky_q;
        rnd = {1'b0, frac_q} + {{MANT_W{1'b0}}, guard_q & (sticky_q | frac_q[0])};
`endif
        case (state_q)
            IDLE: if (START) begin
                sign_d = sa ^ sb;
                mcand_d = {1'b1, fa};
                mplier_d = {1'b1, fb};
                acc_d = '0;
                cnt_d = '0;
                exp_d = XW'(ea) + XW'(eb) - XW'(BIAS);
                spec_d = is_special;
                spec_res_d = is_nan ? QNAN : is_inf ? {sa ^ sb, {EXP_W{1'b1}}, {MANT_W{1'b0}}}
                                                    : {sa ^ sb, {(EXP_W+MANT_W){1'b0}}};
                spec_exc_d = is_nan ? EXC_NAN : is_inf ? EXC_OVER : EXC_NONE;
                state_d = is_special ? FIN : MUL;
            end
            MUL: begin
                acc_d = mplier_q[0] ? acc_q + (PW'(mcand_q) << cnt_q) : acc_q;
                mplier_d = mplier_q >> 1;
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(MW - 1)) ? NORM : MUL;
            end
            NORM: begin
                frac_d = hi ? acc_q[PW-2 -: MANT_W] : acc_q[PW-3 -: MANT_W];
                exp_d = exp_q + XW'(hi);
`ifdef FPMUL_RNE_EN
                guard_d = hi ? acc_q[PW-2-MANT_W] : acc_q[PW-3-MANT_W];
                sticky_d = hi ? |acc_q[PW-3-MANT_W:0] : |acc_q[PW-4-MANT_W:0];
                state_d = ROUND;
`else
                state_d = FIN;
`endif
            end
`ifdef FPMUL_RNE_EN
            // a carry out leaves the fraction bits all zero, so only the exponent needs bumping
            ROUND: begin
                frac_d = rnd[MANT_W-1:0];
                exp_d = exp_q + XW'(rnd[MANT_W]);
                state_d = FIN;
            end
`endif
            FIN: begin
                axb_d = spec_q ? spec_res_q
                      : exp_q >= $signed(XW'(EMAX)) ? {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}}
                      : exp_q <= 0 ? {sign_q, {(EXP_W+MANT_W){1'b0}}}
                      : {sign_q, exp_q[EXP_W-1:0], frac_q};
                exc_d = spec_q ? spec_exc_q : exp_q >= $signed(XW'(EMAX)) ? EXC_OVER
                      : exp_q <= 0 ? EXC_UNDER : EXC_NONE;
                done_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            axb_q <= '0;
            exc_q <= EXC_NONE;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            axb_q <= axb_d;
            exc_q <= exc_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end
    always_ff @(posedge CLOCK) begin
        mcand_q <= mcand_d;
        mplier_q <= mplier_d;
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        exp_q <= exp_d;
        frac_q <= frac_d;
        sign_q <= sign_d;
        spec_q <= spec_d;
        spec_res_q <= spec_res_d;
        spec_exc_q <= spec_exc_d;
`ifdef FPMUL_RNE_EN
        guard_q <= guard_d;
        sticky_q <= sticky_d;
`endif
    end
    assign AxB = axb_q;
    assign Exception = exc_q;
    assign DONE = done_q;
    assign BUSY = busy_q;
endmodule

// File: tb/tb_fp_multiplier_seq.sv
// tb_fp_multiplier_seq: table, corner-sequence and random checks of fp_multiplier_seq against a plain-arithmetic model
module tb_fp_multiplier_seq;
`ifdef FPMUL_RNE_EN
    localparam int LAT = 27;
    localparam logic [31:0] RND_EXP = 32'h3FC0_0002;
`else
    localparam int LAT = 26;
    localparam logic [31:0] RND_EXP = 32'h3FC0_0001;
`endif
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [1:0]  e;
        int          lat;
    } vec_t;
    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [31:0] InputA = '0;
    logic [31:0] InputB = '0;
    logic [31:0] AxB;
    logic        DONE, BUSY;
    logic [1:0]  Exception;
    int          n_cmp = 0;
    int          n_bad = 0;
    always #5 CLOCK = ~CLOCK;
    fp_multiplier_seq dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .InputA(InputA), .InputB(InputB),
        .AxB(AxB), .DONE(DONE), .BUSY(BUSY), .Exception(Exception)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [1:0] e, output int lat);
        logic s;
        int ea, eb, ex, sh;
        logic za, zb, ia, ib, na, nb;
        longint unsigned p, q, rem, half;
        s = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = ea == 0;
        zb = eb == 0;
        ia = ea == 255 && a[22:0] == 0;
        ib = eb == 255 && b[22:0] == 0;
        na = ea == 255 && a[22:0] != 0;
        nb = eb == 255 && b[22:0] != 0;
        lat = 1;
        if (na || nb || (ia && zb) || (za && ib)) begin
            r = 32'h7FC0_0000;
            e = 2'b11;
        end else if (ia || ib) begin
            r = {s, 8'hFF, 23'd0};
            e = 2'b10;
        end else if (za || zb) begin
            r = {s, 31'd0};
            e = 2'b00;
        end else begin
            lat = LAT;
            p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
            sh = (p >= (64'd1 << 47)) ? 24 : 23;
            ex = ea + eb - 127 + sh - 23;
            q = p >> sh;
            rem = p - (q << sh);
            half = 64'd1 << (sh - 1);
`ifdef FPMUL_RNE_EN
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q >= (64'd1 << 24)) begin
                q = q >> 1;
                ex = ex + 1;
            end
`else
            if (rem > half) q = q + 0;
`endif
            if (ex >= 255) begin
                r = {s, 8'hFF, 23'd0};
                e = 2'b10;
            end else if (ex <= 0) begin
                r = {s, 31'd0};
                e = 2'b01;
            end else begin
                r = {s, ex[7:0], q[22:0]};
                e = 2'b00;
            end
        end
    endfunction
    function automatic logic [31:0] rnd_op();
        int k;
        logic [7:0] ex;
        logic [31:0] f;
        k = $urandom_range(0, 11);
        f = $urandom;
        ex = (k == 0) ? 8'd0 : (k == 1) ? 8'hFF : (k < 7) ? 8'($urandom_range(100, 154))
                                                          : 8'($urandom_range(1, 254));
        if (k == 1 && f[31]) f = '0;
        return {f[30], ex, f[22:0]};
    endfunction
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int poke,
                          output logic [31:0] res, output logic [1:0] exc, output int first,
                          output int nd, output logic busy_ok, output logic busy_after);
        res = '0;
        exc = '0;
        first = -1;
        nd = 0;
        busy_ok = 1'b1;
        busy_after = 1'b0;
        InputA = a;
        InputB = b;
        START = 1'b1;
        @(negedge CLOCK);
        for (int c = 0; c < 40; c++) begin
            if (DONE) begin
                nd++;
                if (first < 0) begin
                    first = c;
                    res = AxB;
                    exc = Exception;
                end
            end
            if (first < 0 || first == c) busy_ok &= BUSY;
            if (first >= 0 && c == first + 1) busy_after = BUSY | DONE;
            START = (c == poke);
            if (c == poke) begin
                InputA = 32'h4040_0000;
                InputB = 32'h4040_0000;
            end else if (c == 0) begin
                InputA = $urandom;
                InputB = $urandom;
            end
            @(negedge CLOCK);
        end
    endtask
    initial begin
        vec_t tbl[9];
        logic [31:0] res, mr;
        logic [1:0] exc, me;
        int first, nd, ml;
        logic busy_ok, busy_after;
        tbl[0] = '{32'h4040_0000, 32'h4020_0000, 32'h40F0_0000, 2'b00, LAT};
        tbl[1] = '{32'hBFC0_0000, 32'h4080_0000, 32'hC0C0_0000, 2'b00, LAT};
        tbl[2] = '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 2'b10, LAT};
        tbl[3] = '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 2'b01, LAT};
        tbl[4] = '{32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000, 2'b11, 1};
        tbl[5] = '{32'h3F80_0001, 32'h3FC0_0000, RND_EXP, 2'b00, LAT};
        tbl[6] = '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 2'b10, 1};
        tbl[7] = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 2'b00, 1};
        tbl[8] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 2'b11, 1};
        repeat (3) @(negedge CLOCK);
        chk("reset axb", AxB, 32'h0);
        chk("reset done", 32'(DONE), 32'h0);
        chk("reset busy", 32'(BUSY), 32'h0);
        chk("reset exc", 32'(Exception), 32'h0);
        RESET = 1'b0;
        @(negedge CLOCK);
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].a, tbl[i].b, -1, res, exc, first, nd, busy_ok, busy_after);
            chk($sformatf("vec%0d axb", i), res, tbl[i].r);
            chk($sformatf("vec%0d exc", i), 32'(exc), 32'(tbl[i].e));
            chk($sformatf("vec%0d latency", i), 32'(first), 32'(tbl[i].lat));
            chk($sformatf("vec%0d done count", i), 32'(nd), 32'd1);
            chk($sformatf("vec%0d busy held", i), 32'(busy_ok), 32'd1);
            chk($sformatf("vec%0d busy drop", i), 32'(busy_after), 32'd0);
        end
        run_op(32'hBFC0_0000, 32'h4080_0000, 9, res, exc, first, nd, busy_ok, busy_after);
        chk("restart axb", res, 32'hC0C0_0000);
        chk("restart latency", 32'(first), 32'(LAT));
        chk("restart done count", 32'(nd), 32'd1);
        InputA = 32'h4040_0000;
        InputB = 32'h4020_0000;
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        repeat (9) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        chk("abort busy", 32'(BUSY), 32'h0);
        chk("abort axb", AxB, 32'h0);
        chk("abort done", 32'(DONE), 32'h0);
        nd = 0;
        repeat (40) begin
            if (DONE) nd++;
            @(negedge CLOCK);
        end
        chk("abort no done", 32'(nd), 32'h0);
        run_op(32'h4040_0000, 32'h4020_0000, -1, res, exc, first, nd, busy_ok, busy_after);
        chk("recover axb", res, 32'h40F0_0000);
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            a = rnd_op();
            b = rnd_op();
            ref_mul(a, b, mr, me, ml);
            run_op(a, b, -1, res, exc, first, nd, busy_ok, busy_after);
            chk($sformatf("rand%0d %h*%h axb", i, a, b), res, mr);
            chk($sformatf("rand%0d exc", i), 32'(exc), 32'(me));
            chk($sformatf("rand%0d latency", i), 32'(first), 32'(ml));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
